// File: rtl/ahbl_sram_resp.sv
// AHB-Lite SRAM slave: word-organised memory with configurable wait states,
// two-cycle ERROR response for bad transfers, and read-after-write bypass.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   ahbls_hsel/haddr/htrans/hwrite/hsize/hready - address phase inputs
//   ahbls_hwdata        - write data (data phase)
//   ahbls_hready_resp   - this slave's HREADYOUT
//   ahbls_hresp         - 0 OKAY, 1 ERROR
//   ahbls_hrdata        - read data (valid in final cycle of a read)
module ahbl_sram_resp #(
   parameter int W_ADDR      = 32,
   parameter int W_DATA      = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ahbls_hsel,
   input  logic [W_ADDR-1:0] ahbls_haddr,
   input  logic [1:0]        ahbls_htrans,
   input  logic              ahbls_hwrite,
   input  logic [2:0]        ahbls_hsize,
   input  logic              ahbls_hready,
   output logic              ahbls_hready_resp,
   output logic              ahbls_hresp,
   input  logic [W_DATA-1:0] ahbls_hwdata,
   output logic [W_DATA-1:0] ahbls_hrdata
);

   localparam int N_WORDS = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2
   } state_t;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;

   logic [DEPTH_LOG2+1:0] addr_q;
   logic [1:0]            size_q;
   logic                  write_q;
   logic [W_DATA-1:0]     rdata_q;

   logic [W_DATA-1:0] mem [N_WORDS];

   logic                  accept;
   logic                  err;
   logic                  commit;
   logic [3:0]            be;
   logic [W_DATA-1:0]     wmask;
   logic [DEPTH_LOG2-1:0] widx;
   logic [DEPTH_LOG2-1:0] ridx;
   logic [W_DATA-1:0]     rd_word;

   // htrans[0] only distinguishes NSEQ/SEQ, which this slave treats alike
   logic unused_ok;
   assign unused_ok = ahbls_htrans[0];

   assign ahbls_hready_resp = (state == S_IDLE) || (state == S_LAST)
                           || (state == S_ERR2);
   assign ahbls_hresp = (state == S_ERR1) || (state == S_ERR2);

   // Gating with our own ready keeps a stalled address phase from being
   // taken even if the bus-wide hready is wired loosely.
   assign accept = ahbls_hsel && ahbls_htrans[1] && ahbls_hready
                && ahbls_hready_resp;

   assign err = (ahbls_hsize > 3'd2)
             || ((ahbls_hsize == 3'd1) && ahbls_haddr[0])
             || ((ahbls_hsize == 3'd2) && (ahbls_haddr[1:0] != 2'b00))
             || (|ahbls_haddr[W_ADDR-1:DEPTH_LOG2+2]);

   assign commit = (state == S_LAST) && write_q;
   assign widx   = addr_q[DEPTH_LOG2+1:2];
   assign ridx   = ahbls_haddr[DEPTH_LOG2+1:2];

   always_comb begin
      be = 4'b1111;
      case (size_q)
         2'd0:    be = 4'b0001 << addr_q[1:0];
         2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

   // A write committing this edge to the word being read must be visible
   always_comb begin
      rd_word = mem[ridx];
      if (commit && (widx == ridx))
         rd_word = (rd_word & ~wmask) | (ahbls_hwdata & wmask);
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_WAIT: begin
            if (cnt == 4'd0) state_nxt = S_LAST;
            else             cnt_nxt   = cnt - 4'd1;
         end
         S_ERR1: state_nxt = S_ERR2;
         default: begin
            if (!accept) begin
               state_nxt = S_IDLE;
            end else if (err) begin
               state_nxt = S_ERR1;
            end else if (WAIT_STATES > 0) begin
               state_nxt = S_WAIT;
               cnt_nxt   = CNT_LOAD;
            end else begin
               state_nxt = S_LAST;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         rdata_q <= '0;
         addr_q  <= '0;
         size_q  <= 2'd0;
         write_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            addr_q  <= ahbls_haddr[DEPTH_LOG2+1:0];
            size_q  <= ahbls_hsize[1:0];
            write_q <= ahbls_hwrite;
            rdata_q <= rd_word;
         end
      end
   end

   // Memory is not reset; a reset edge drops any pending write
   always_ff @(posedge clk) begin
      if (rst_n && commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= ahbls_hwdata[8*i +: 8];
         end
      end
   end

   assign ahbls_hrdata = ((state == S_LAST) && !write_q) ? rdata_q : '0;

endmodule

// File: tb/tb_ahbl_sram_resp.sv
// Self-checking bench for ahbl_sram_resp: zero-wait instance driven from a
// cycle table, three-wait instance driven by hand-written sequences.
module tb_ahbl_sram_resp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel0, hsel3;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        rdy0, resp0, rdy3, resp3;
   logic [31:0] rdata0, rdata3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ahbl_sram_resp #(
      .W_ADDR(32), .W_DATA(32), .DEPTH_LOG2(10), .WAIT_STATES(0)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .ahbls_hsel(hsel0), .ahbls_haddr(haddr), .ahbls_htrans(htrans),
      .ahbls_hwrite(hwrite), .ahbls_hsize(hsize), .ahbls_hready(rdy0),
      .ahbls_hready_resp(rdy0), .ahbls_hresp(resp0),
      .ahbls_hwdata(hwdata), .ahbls_hrdata(rdata0)
   );

   ahbl_sram_resp #(
      .W_ADDR(32), .W_DATA(32), .DEPTH_LOG2(10), .WAIT_STATES(3)
   ) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .ahbls_hsel(hsel3), .ahbls_haddr(haddr), .ahbls_htrans(htrans),
      .ahbls_hwrite(hwrite), .ahbls_hsize(hsize), .ahbls_hready(rdy3),
      .ahbls_hready_resp(rdy3), .ahbls_hresp(resp3),
      .ahbls_hwdata(hwdata), .ahbls_hrdata(rdata3)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        e_rdy;
      logic        e_resp;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl [28];

   function automatic vec_t mk(logic sel, logic [1:0] trans, logic wr,
                               logic [2:0] size, logic [31:0] addr,
                               logic [31:0] wdata, logic e_rdy,
                               logic e_resp, logic [31:0] e_rdata);
      vec_t v;
      v.sel = sel; v.trans = trans; v.wr = wr; v.size = size;
      v.addr = addr; v.wdata = wdata;
      v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_rdata = e_rdata;
      return v;
   endfunction

   task automatic chk_out(string name, logic rdy, logic resp,
                          logic [31:0] rdata, logic e_rdy, logic e_resp,
                          logic [31:0] e_rdata);
      checks++;
      if (rdy !== e_rdy || resp !== e_resp || rdata !== e_rdata) begin
         failures++;
         $display("FAIL %s: got rdy=%b resp=%b rdata=%08h want rdy=%b resp=%b rdata=%08h",
                  name, rdy, resp, rdata, e_rdy, e_resp, e_rdata);
      end
   endtask

   task automatic chk_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0;
      hwrite = 1'b0; hsize = 3'd0; haddr = 32'h0;
   endtask

   // Counts low-ready cycles of dut3; returns at the negedge where it is high
   task automatic wait_ready3(output int n);
      n = 0;
      @(negedge clk);
      while (!rdy3 && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;

      tbl[0]  = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h0);
      tbl[1]  = mk(1, 2, 1, 2, 32'h10, 32'h0,        1, 0, 32'h0);
      tbl[2]  = mk(1, 2, 0, 2, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0);
      tbl[3]  = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF);
      tbl[4]  = mk(1, 2, 1, 2, 32'h20, 32'h0,        1, 0, 32'h0);
      tbl[5]  = mk(1, 2, 1, 0, 32'h21, 32'h0,        1, 0, 32'h0);
      tbl[6]  = mk(1, 2, 0, 2, 32'h20, 32'h0000AB00, 1, 0, 32'h0);
      tbl[7]  = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h0000AB00);
      tbl[8]  = mk(1, 2, 1, 2, 32'h00, 32'h0,        1, 0, 32'h0);
      tbl[9]  = mk(1, 2, 1, 1, 32'h03, 32'h11223344, 1, 0, 32'h0);
      tbl[10] = mk(0, 0, 0, 0, 32'h00, 32'hFFFFFFFF, 0, 1, 32'h0);
      tbl[11] = mk(0, 0, 0, 0, 32'h00, 32'hFFFFFFFF, 1, 1, 32'h0);
      tbl[12] = mk(1, 2, 0, 2, 32'h00, 32'h0,        1, 0, 32'h0);
      tbl[13] = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h11223344);
      tbl[14] = mk(1, 2, 0, 2, 32'h1000, 32'h0,      1, 0, 32'h0);
      tbl[15] = mk(1, 2, 1, 2, 32'h00, 32'h0,        0, 1, 32'h0);
      tbl[16] = mk(1, 2, 0, 2, 32'h10, 32'h55555555, 1, 1, 32'h0);
      tbl[17] = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'hDEADBEEF);
      tbl[18] = mk(1, 2, 0, 2, 32'h00, 32'h0,        1, 0, 32'h0);
      tbl[19] = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h11223344);
      tbl[20] = mk(1, 1, 1, 2, 32'h00, 32'h0,        1, 0, 32'h0);
      tbl[21] = mk(0, 2, 1, 2, 32'h00, 32'h0,        1, 0, 32'h0);
      tbl[22] = mk(1, 2, 0, 1, 32'h02, 32'h0,        1, 0, 32'h0);
      tbl[23] = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h11223344);
      tbl[24] = mk(1, 2, 1, 1, 32'h02, 32'h0,        1, 0, 32'h0);
      tbl[25] = mk(1, 2, 0, 2, 32'h00, 32'hBEEF0000, 1, 0, 32'h0);
      tbl[26] = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'hBEEF3344);
      tbl[27] = mk(0, 0, 0, 0, 32'h00, 32'h0,        1, 0, 32'h0);

      rst_n = 1'b0;
      bus_idle();
      hwdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset_dut0", rdy0, resp0, rdata0, 1, 0, 32'h0);
      chk_out("reset_dut3", rdy3, resp3, rdata3, 1, 0, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 28; i++) begin
         @(posedge clk);
         #1;
         hsel0  = tbl[i].sel;
         htrans = tbl[i].trans;
         hwrite = tbl[i].wr;
         hsize  = tbl[i].size;
         haddr  = tbl[i].addr;
         hwdata = tbl[i].wdata;
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), rdy0, resp0, rdata0,
                 tbl[i].e_rdy, tbl[i].e_resp, tbl[i].e_rdata);
      end

      @(posedge clk);
      #1;
      bus_idle();
      hsel3 = 1'b1; htrans = 2'd2; hwrite = 1'b1;
      hsize = 3'd2; haddr = 32'h40;
      @(posedge clk);
      #1;
      bus_idle();
      hwdata = 32'hCAFEF00D;
      wait_ready3(n);
      chk_int("ws3_write_stalls", n, 3);
      chk_out("ws3_write_last", rdy3, resp3, rdata3, 1, 0, 32'h0);

      hsel3 = 1'b1; htrans = 2'd2; hwrite = 1'b0;
      hsize = 3'd2; haddr = 32'h40;
      @(posedge clk);
      #1;
      bus_idle();
      hwdata = 32'h0;
      wait_ready3(n);
      chk_int("ws3_read_stalls", n, 3);
      chk_out("ws3_read_data", rdy3, resp3, rdata3, 1, 0, 32'hCAFEF00D);

      @(posedge clk);
      #1;
      hsel3 = 1'b1; htrans = 2'd2; hwrite = 1'b1;
      hsize = 3'd2; haddr = 32'h40;
      @(posedge clk);
      #1;
      bus_idle();
      hwdata = 32'h12345678;
      @(negedge clk);
      chk_out("rst_pre_wait", rdy3, resp3, rdata3, 0, 0, 32'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_out("rst_in_wait", rdy3, resp3, rdata3, 1, 0, 32'h0);

      hsel3 = 1'b1; htrans = 2'd2; hwrite = 1'b0;
      hsize = 3'd2; haddr = 32'h40;
      @(posedge clk);
      #1;
      bus_idle();
      hwdata = 32'h0;
      wait_ready3(n);
      chk_int("rst_read_stalls", n, 3);
      chk_out("rst_word_kept", rdy3, resp3, rdata3, 1, 0, 32'hCAFEF00D);

      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
